// File: rtl/apb_gpio_slave.sv
// apb_gpio_slave: APB3 completer holding a GPIO register bank with optional edge-detect IRQ.
// Latency: PREADY rises 1+WAIT_STATES cycles after the setup cycle (2+WAIT_STATES cycle transfer).
// Backpressure: the completer stalls the bridge with PREADY=0 for WAIT_STATES access cycles.
//
// Ports:
//   PCLK, PRESET            clock and synchronous active-high reset
//   PSEL, PENABLE, PWRITE,
//   PADDR[7:0], PWDATA[31:0] APB request from the bridge (PADDR[1:0] ignored)
//   PRDATA, PREADY, PSLVERR  registered APB response
//   GPIO_IN                 asynchronous pad inputs (2-flop synchronized)
//   GPIO_OUT, GPIO_OE       output and output-enable registers
//   IRQ                     registered interrupt, |(IRQ_STAT & IRQ_EN)
//
// Build option: define APB_GPIO_IRQ_EN to build the edge detector and the
// IRQ_EN / IRQ_STAT / EDGE_POL registers. Without it those addresses decode
// as unmapped (PSLVERR=1) and IRQ is tied low.
//
// Register map (word index = PADDR[7:2]):
//   0x00 OUT rw, 0x04 OE rw, 0x08 IN ro, 0x0C IRQ_EN rw,
//   0x10 IRQ_STAT w1c, 0x14 EDGE_POL rw (1 = rising, 0 = falling)

module apb_gpio_slave #(
    parameter int unsigned GPIO_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [GPIO_W-1:0] GPIO_IN,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic [GPIO_W-1:0] GPIO_OE,
    output logic              IRQ
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [5:0] IDX_OUT  = 6'd0;
    localparam logic [5:0] IDX_OE   = 6'd1;
    localparam logic [5:0] IDX_IN   = 6'd2;
    localparam logic [5:0] IDX_EN   = 6'd3;
    localparam logic [5:0] IDX_STAT = 6'd4;
    localparam logic [5:0] IDX_POL  = 6'd5;

    // The setup phase is the cycle in which IDLE samples PSEL & ~PENABLE;
    // ACCESS covers every access-phase cycle up to and including the
    // PREADY cycle. Because PREADY is registered, it is raised one edge
    // ahead: on the edge where the wait counter would reach zero.
    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              finish;
    logic              commit;

    logic [5:0]        idx;
    logic [GPIO_W-1:0] wdat;
    logic              addr_ok;
    logic              acc_err;
    logic [31:0]       rd_dat;

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] oe_q, oe_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;

    // Byte lane bits and write data above GPIO_W carry no meaning here.
    logic              unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign idx  = PADDR[7:2];
    assign wdat = PWDATA[GPIO_W-1:0];

`ifdef APB_GPIO_IRQ_EN
    logic [GPIO_W-1:0] prev_q;
    logic [GPIO_W-1:0] en_q, en_d;
    logic [GPIO_W-1:0] stat_q, stat_d;
    logic [GPIO_W-1:0] pol_q, pol_d;
    logic [GPIO_W-1:0] rise, fall, edge_hit;
    logic              irq_q, irq_d;
`endif

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    always_comb begin
        addr_ok = 1'b0;
        rd_dat  = '0;
        case (idx)
            IDX_OUT: begin
                addr_ok                = 1'b1;
                rd_dat[GPIO_W-1:0]     = out_q;
            end
            IDX_OE: begin
                addr_ok                = 1'b1;
                rd_dat[GPIO_W-1:0]     = oe_q;
            end
            IDX_IN: begin
                addr_ok                = 1'b1;
                rd_dat[GPIO_W-1:0]     = sync2_q;
            end
`ifdef APB_GPIO_IRQ_EN
            IDX_EN: begin
                addr_ok                = 1'b1;
                rd_dat[GPIO_W-1:0]     = en_q;
            end
            IDX_STAT: begin
                addr_ok                = 1'b1;
                rd_dat[GPIO_W-1:0]     = stat_q;
            end
            IDX_POL: begin
                addr_ok                = 1'b1;
                rd_dat[GPIO_W-1:0]     = pol_q;
            end
`endif
            default: ;
        endcase
        // IN is read-only: writing it is an error, not a silent drop.
        acc_err = !addr_ok || (PWRITE && (idx == IDX_IN));
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        commit    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // PSEL & PENABLE seen here is a protocol violation: ignored.
                if (PSEL && !PENABLE) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_INIT;
                    finish  = (WAIT_INIT == 4'd0);
                end
            end
            ST_ACCESS: begin
                if (pready_q) begin
                    // PREADY cycle: the closing edge commits the write.
                    state_d = ST_IDLE;
                    commit  = PWRITE && !pslverr_q;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    finish = (cnt_q == 4'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (finish) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = (PWRITE || acc_err) ? 32'd0 : rd_dat;
        end
    end

    // ------------------------------------------------------------------
    // Register bank next state
    // ------------------------------------------------------------------
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        if (commit) begin
            case (idx)
                IDX_OUT: out_d = wdat;
                IDX_OE:  oe_d  = wdat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            sync1_q   <= GPIO_IN;
            sync2_q   <= sync1_q;
        end
    end

`ifdef APB_GPIO_IRQ_EN
    // ------------------------------------------------------------------
    // Edge detect and interrupt registers
    // ------------------------------------------------------------------
    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign edge_hit = (pol_q & rise) | (~pol_q & fall);

    always_comb begin
        en_d   = en_q;
        pol_d  = pol_q;
        stat_d = stat_q;
        if (commit) begin
            case (idx)
                IDX_EN:   en_d   = wdat;
                IDX_STAT: stat_d = stat_q & ~wdat;
                IDX_POL:  pol_d  = wdat;
                default: ;
            endcase
        end
        // OR-ing the edge in after the clear makes a same-cycle set win.
        stat_d = stat_d | edge_hit;
        irq_d  = |(stat_q & en_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prev_q <= '0;
            en_q   <= '0;
            stat_q <= '0;
            pol_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            en_q   <= en_d;
            stat_q <= stat_d;
            pol_q  <= pol_d;
            irq_q  <= irq_d;
        end
    end

    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign GPIO_OUT = out_q;
    assign GPIO_OE  = oe_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// tb_apb_gpio_slave: vector table, hand-timed corner sequences and a randomized run.
// Latency: each transfer is expected to take 2+WS cycles including setup.
// Backpressure: the bench master holds the access phase until PREADY.

module tb_apb_gpio_slave;

    localparam int GPIO_W = 8;
    localparam int WS     = 2;
`ifdef APB_GPIO_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  GPIO_IN, GPIO_OUT, GPIO_OE;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_gpio_slave #(.GPIO_W(GPIO_W), .WAIT_STATES(WS)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_IN(GPIO_IN),
        .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  out;
        logic [7:0]  oe;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [7:0] m_out, m_oe, m_in, m_en, m_stat, m_pol;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLK);
            PSEL    = 1'b0;
            PENABLE = 1'b0;
        end
    endtask

    // One APB transfer. Returns at the negedge of the PREADY cycle with the
    // bus still held, so the caller may start the next setup immediately.
    // pad_cyc selects the transfer cycle in which GPIO_IN is set to pad_val.
    task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                        input int pad_cyc, input logic [7:0] pad_val,
                        output logic [31:0] rdata, output logic err, output int cyc);
        @(negedge PCLK);
        chk("pready_one_cycle", {31'd0, PREADY}, 32'd0);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        cyc     = 1;
        rdata   = '0;
        err     = 1'b0;
        if (pad_cyc == 1) GPIO_IN = pad_val;
        do begin
            @(negedge PCLK);
            cyc++;
            PENABLE = 1'b1;
            if (cyc == pad_cyc) GPIO_IN = pad_val;
        end while (!PREADY && cyc < 40);
        if (!PREADY) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: addr 0x%0h got no PREADY in %0d cycles, expected %0d", addr, cyc, 2 + WS);
        end else begin
            rdata = PRDATA;
            err   = PSLVERR;
        end
    endtask

    function automatic bit mapped(input int idx);
        return (idx <= 2) || (IRQ_BUILT && idx <= 5);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        logic [7:0]  prev_out;
        logic [7:0]  addr, nv;
        logic        wr;
        logic [31:0] wd, exp_rd;
        logic        exp_err;
        int          idx;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; GPIO_IN = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pready", {31'd0, PREADY}, 0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 0);
        chk("rst_irq", {31'd0, IRQ}, 0);
        chk("rst_out", {24'd0, GPIO_OUT}, 0);
        chk("rst_oe", {24'd0, GPIO_OE}, 0);
        PRESET = 1'b0;

        // ---------------- vector table ----------------
        vecs.push_back('{8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h04, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h08, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h0C, 1'b0, 32'h0, 32'h0, !IRQ_BUILT, 8'h00, 8'h00});
        vecs.push_back('{8'h10, 1'b0, 32'h0, 32'h0, !IRQ_BUILT, 8'h00, 8'h00});
        vecs.push_back('{8'h14, 1'b0, 32'h0, 32'h0, !IRQ_BUILT, 8'h00, 8'h00});
        vecs.push_back('{8'h00, 1'b1, 32'hA5, 32'h0, 1'b0, 8'hA5, 8'h00});
        vecs.push_back('{8'h04, 1'b1, 32'h0F, 32'h0, 1'b0, 8'hA5, 8'h0F});
        vecs.push_back('{8'h00, 1'b0, 32'h0, 32'hA5, 1'b0, 8'hA5, 8'h0F});
        vecs.push_back('{8'h04, 1'b0, 32'h0, 32'h0F, 1'b0, 8'hA5, 8'h0F});
        vecs.push_back('{8'h03, 1'b0, 32'h0, 32'hA5, 1'b0, 8'hA5, 8'h0F});
        vecs.push_back('{8'h18, 1'b0, 32'h0, 32'h0, 1'b1, 8'hA5, 8'h0F});
        vecs.push_back('{8'h08, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 8'hA5, 8'h0F});
        vecs.push_back('{8'h08, 1'b0, 32'h0, 32'h0, 1'b0, 8'hA5, 8'h0F});
        vecs.push_back('{8'h1C, 1'b1, 32'h12, 32'h0, 1'b1, 8'hA5, 8'h0F});
        vecs.push_back('{8'h00, 1'b0, 32'h0, 32'hA5, 1'b0, 8'hA5, 8'h0F});
        vecs.push_back('{8'h00, 1'b1, 32'hFFFFFF5A, 32'h0, 1'b0, 8'h5A, 8'h0F});
        vecs.push_back('{8'h00, 1'b0, 32'h0, 32'h5A, 1'b0, 8'h5A, 8'h0F});

        prev_out = 8'h00;
        foreach (vecs[i]) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 0, 8'h00, rd, er, cyc);
            chk($sformatf("vec%0d_cycles", i), cyc, 2 + WS);
            chk($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vecs[i].err});
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d_out_before_commit", i), {24'd0, GPIO_OUT}, {24'd0, prev_out});
            idle(1);
            chk($sformatf("vec%0d_out", i), {24'd0, GPIO_OUT}, {24'd0, vecs[i].out});
            chk($sformatf("vec%0d_oe", i), {24'd0, GPIO_OE}, {24'd0, vecs[i].oe});
            chk($sformatf("vec%0d_prdata_idle", i), PRDATA, 0);
            prev_out = vecs[i].out;
        end

        // ---------------- back-to-back transfers ----------------
        xfer(8'h00, 1'b1, 32'h3C, 0, 8'h00, rd, er, cyc);
        chk("b2b_wr_cycles", cyc, 2 + WS);
        xfer(8'h00, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("b2b_rd_cycles", cyc, 2 + WS);
        chk("b2b_rd_data", rd, 32'h3C);
        idle(1);

        // ---------------- PSEL&PENABLE in IDLE is ignored ----------------
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h77;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            chk($sformatf("viol_pready%0d", k), {31'd0, PREADY}, 0);
        end
        idle(2);
        chk("viol_out_kept", {24'd0, GPIO_OUT}, 32'h3C);

`ifdef APB_GPIO_IRQ_EN
        // ---------------- edge interrupt and latency ----------------
        xfer(8'h14, 1'b1, 32'h01, 0, 8'h00, rd, er, cyc);
        xfer(8'h0C, 1'b1, 32'h01, 0, 8'h00, rd, er, cyc);
        idle(2);
        GPIO_IN = 8'h01;
        @(negedge PCLK);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("irq_low_after_3_edges", {31'd0, IRQ}, 0);
        @(negedge PCLK);
        chk("irq_high_after_4_edges", {31'd0, IRQ}, 1);
        xfer(8'h10, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("irq_stat_set", rd, 32'h01);
        xfer(8'h08, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("in_reads_pad", rd, 32'h01);
        xfer(8'h10, 1'b1, 32'h01, 0, 8'h00, rd, er, cyc);
        chk("irq_at_w1c_ready", {31'd0, IRQ}, 1);
        idle(1);
        chk("irq_after_commit_edge", {31'd0, IRQ}, 1);
        idle(1);
        chk("irq_dropped", {31'd0, IRQ}, 0);
        xfer(8'h10, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("irq_stat_cleared", rd, 32'h0);
        idle(1);

        // ---------------- same-cycle set and clear ----------------
        GPIO_IN = 8'h00; idle(5);
        GPIO_IN = 8'h01; idle(5);
        GPIO_IN = 8'h00; idle(5);
        chk("sc_irq_pre", {31'd0, IRQ}, 1);
        // Pad rises in cycle 2 so the edge is seen in the PREADY cycle (cycle 4).
        xfer(8'h10, 1'b1, 32'h01, 2, 8'h01, rd, er, cyc);
        idle(2);
        chk("sc_irq_kept", {31'd0, IRQ}, 1);
        xfer(8'h10, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("sc_stat_set_wins", rd, 32'h01);
        idle(1);
`else
        GPIO_IN = 8'h01; idle(6);
        chk("noirq_irq_low", {31'd0, IRQ}, 0);
        xfer(8'h08, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("noirq_in_reads_pad", rd, 32'h01);
        xfer(8'h10, 1'b1, 32'h01, 0, 8'h00, rd, er, cyc);
        chk("noirq_stat_err", {31'd0, er}, 1);
        idle(1);
`endif

        // ---------------- reset during ACCESS of a write ----------------
        GPIO_IN = 8'h00;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hFF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rstmid_not_ready", {31'd0, PREADY}, 0);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rstmid_out", {24'd0, GPIO_OUT}, 0);
        chk("rstmid_pready", {31'd0, PREADY}, 0);
        chk("rstmid_oe", {24'd0, GPIO_OE}, 0);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        idle(3);
        chk("rstmid_out_later", {24'd0, GPIO_OUT}, 0);
        xfer(8'h04, 1'b1, 32'h33, 0, 8'h00, rd, er, cyc);
        chk("rstmid_next_cycles", cyc, 2 + WS);
        xfer(8'h04, 1'b0, 32'h0, 0, 8'h00, rd, er, cyc);
        chk("rstmid_next_rd", rd, 32'h33);
        idle(1);

        // ---------------- randomized run against the model ----------------
        PRESET = 1'b1; GPIO_IN = 8'h00;
        idle(3);
        PRESET = 1'b0;
        m_out = 0; m_oe = 0; m_in = 0; m_en = 0; m_stat = 0; m_pol = 0;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                nv = 8'($urandom);
                m_stat = m_stat | (m_pol & nv & ~m_in) | (~m_pol & ~nv & m_in);
                m_in = nv;
                GPIO_IN = nv;
                idle(5);
            end else begin
                addr = 8'($urandom_range(0, 31));
                wr   = 1'($urandom_range(0, 1));
                wd   = $urandom;
                idx  = int'(addr[7:2]);
                exp_err = !mapped(idx) || (wr && idx == 2);
                exp_rd  = 32'd0;
                if (!exp_err && !wr) begin
                    case (idx)
                        0: exp_rd = {24'd0, m_out};
                        1: exp_rd = {24'd0, m_oe};
                        2: exp_rd = {24'd0, m_in};
                        3: exp_rd = {24'd0, m_en};
                        4: exp_rd = {24'd0, m_stat};
                        default: exp_rd = {24'd0, m_pol};
                    endcase
                end
                xfer(addr, wr, wd, 0, 8'h00, rd, er, cyc);
                chk($sformatf("rnd%0d_cycles", n), cyc, 2 + WS);
                chk($sformatf("rnd%0d_err a=%0h w=%0d", n, addr, wr), {31'd0, er}, {31'd0, exp_err});
                chk($sformatf("rnd%0d_rdata a=%0h", n, addr), rd, exp_rd);
                if (!exp_err && wr) begin
                    case (idx)
                        0: m_out = wd[7:0];
                        1: m_oe  = wd[7:0];
                        3: m_en  = wd[7:0];
                        4: m_stat = m_stat & ~wd[7:0];
                        default: m_pol = wd[7:0];
                    endcase
                end
                idle(2);
            end
            chk($sformatf("rnd%0d_out", n), {24'd0, GPIO_OUT}, {24'd0, m_out});
            chk($sformatf("rnd%0d_oe", n), {24'd0, GPIO_OE}, {24'd0, m_oe});
            chk($sformatf("rnd%0d_irq", n), {31'd0, IRQ}, {31'd0, IRQ_BUILT && (|(m_stat & m_en))});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
